fetch_stage: RTL
================

# fetch_stage

Fetch stage of the pipelined core, directly upstream of the decode stage. It owns the program counter and issues word requests to instruction memory over a request/valid handshake that tolerates variable latency. It drives the fetch/decode pipeline register (`inst`, `pc`, `pcPlus8`, `instValid`) consumed by decode. `pcPlus8` is the R15 read value. The stage supports decode stalls through a one-entry skid buffer and branch redirects that squash in-flight fetches.

## Interface
- `N`, 32: data/address width.
- `RESET_PC`, 32'h0: first fetch address after reset.

- `clk`  in  1  clock, all state on rising edge.
- `reset`  in  1  synchronous, active-high.
- `stallD`  in  1  decode cannot accept; F/D register must hold.
- `pcSrc`  in  1  redirect request from execute (branch taken).
- `branchTarget`  in  N  redirect address, valid when `pcSrc`=1.
- `imemReq`  out  1  instruction memory request.
- `imemAddr`  out  N  request address; stable while `imemReq`=1 until accepted.
- `imemRdata`  in  N  returned instruction word.
- `imemValid`  in  1  response strobe; completes the outstanding request. May assert in the same cycle as `imemReq`.
- `inst`  out  N  F/D instruction to decode.
- `pc`  out  N  address of `inst`.
- `pcPlus8`  out  N  `pc`+8, R15 value for the register file.
- `instValid`  out  1  F/D register holds a real instruction (0 = bubble).

## Operation
- Internal state:
  - `pcF`: next fetch address.
  - `reqAddr`: address of the outstanding request; drives `imemAddr`.
  - Skid register {`skidInst`, `skidPc`}.
  - FSM with states IDLE, WAIT, HOLD, DROP.
- "Output free" means `instValid`=0 or `stallD`=0.
- IDLE: `imemReq`=0. Next state is WAIT, with `reqAddr`←`pcF`.
- WAIT: `imemReq`=1.
  - On `imemValid` with output free:
    - F/D ← {`imemRdata`, `reqAddr`}, `instValid`←1.
    - `pcF`←`pcF`+4 and `reqAddr`←`pcF`+4.
    - Stay in WAIT.
  - On `imemValid` with output not free:
    - Skid ← {`imemRdata`, `reqAddr`}.
    - `pcF`←`pcF`+4.
    - Go to HOLD.
  - No `imemValid` and `stallD`=0: `instValid`←0 (bubble).
- HOLD: `imemReq`=0; F/D holds while `stallD`=1. When `stallD`=0:
  - F/D ← skid, `instValid`←1.
  - `reqAddr`←`pcF`.
  - Go to WAIT.
- DROP: a request was outstanding when a redirect occurred.
  - `imemReq`=1 and `imemAddr`=old `reqAddr` are held, as the protocol requires.
  - On `imemValid`: discard the data, `reqAddr`←`pcF`, go to WAIT.
- Redirect (`pcSrc`=1) has the highest priority in every state and overrides `stallD`:
  - `instValid`←0 and the skid buffer is invalidated.
  - `pcF`←`branchTarget`.
  - If in WAIT with `imemValid`=0: go to DROP.
  - If in WAIT with `imemValid`=1 in the same cycle: the response is discarded, `reqAddr`←`branchTarget`, stay in WAIT.
  - From HOLD or IDLE: `reqAddr`←`branchTarget`, go to WAIT.
  - In DROP: `pcF` is updated and DROP continues.
- Arithmetic: `pcF`+4 and `pc`+8 are modulo 2^N; wrap from 32'hFFFFFFFC to 0 silently. `branchTarget` bits [1:0] are forced to 0.
- `stallD`=1 with `instValid`=0: the F/D register may load; a bubble does not block.

## Timing
- Reset values:
  - `imemReq`=0, `instValid`=0.
  - `inst`=0, `pc`=0, `pcPlus8`=8.
  - `pcF`=`reqAddr`=`RESET_PC`.
  - State IDLE, skid empty.
- Reset asserted mid-transaction abandons any outstanding request. Memory must drop it on reset as well.
- First request: `imemReq`=1 at `RESET_PC` in the second cycle after `reset` deasserts.
- Fetch-to-decode latency: `inst`/`instValid` update on the edge ending the cycle in which `imemValid`=1.
- Throughput: 1 instruction/cycle with a zero-wait memory (`imemValid` tied 1) and `stallD`=0.
- Redirect penalty: the first target instruction reaches F/D no earlier than 1 cycle after the `pcSrc` cycle (zero-wait memory). Add 1 + remaining latency if DROP is entered.
- `pcPlus8` is registered together with `pc` and is never combinational from the inputs.

## Test plan
- Reset, zero-wait memory, `stallD`=0 -> F/D `pc` = 0, 4, 8, 12 on consecutive cycles; `pcPlus8` = 8, 12, 16, 20; `imemAddr` never changes while a request is pending.
- Memory with 3-cycle latency -> `imemAddr`=0 held for 3 cycles, then `inst` loaded and `instValid`=1 for exactly 1 cycle followed by bubbles until the next response.
- `stallD`=1 for 4 cycles while holding the instruction at `pc`=8, response for 12 arrives -> state HOLD, `imemReq`=0, F/D stays at 8; on `stallD`=0, F/D=12, next request at 16, nothing lost or duplicated.
- `pcSrc`=1, `branchTarget`=32'h100, while a request for 20 is outstanding (latency 2) -> DROP, the response for 20 is discarded with `instValid`=0; the next request is at 32'h100 and F/D `pc`=32'h100 arrives next.
- `pcSrc`=1 in the same cycle as `imemValid` and `stallD`=1 -> redirect wins; F/D becomes a bubble and the next `imemAddr`=`branchTarget`.
- `branchTarget`=32'hFFFFFFFC, zero-wait -> F/D `pc` = FFFFFFFC then 0; `pcPlus8` = 4 then 8.

Source files
------------

// File: rtl/fetch_stage.sv
// Fetch stage: owns the program counter and issues word requests to
// instruction memory over a variable-latency request/valid handshake. It drives
// the F/D pipeline register, with a one-entry skid buffer for decode stalls and
// squashing of in-flight fetches on branch redirect.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no request; next cycle starts a fetch at pcF
// WAIT  | request at reqAddr outstanding, imemReq asserted
// HOLD  | response parked in skid buffer, waiting for decode to free up
// DROP  | stale request still outstanding after redirect; response discarded
module fetch_stage #(
    parameter int unsigned     N        = 32,
    parameter logic [N-1:0]    RESET_PC = '0
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         stallD_i,
    input  logic         pcSrc_i,
    input  logic [N-1:0] branchTarget_i,
    output logic         imemReq_o,
    output logic [N-1:0] imemAddr_o,
    input  logic [N-1:0] imemRdata_i,
    input  logic         imemValid_i,
    output logic [N-1:0] inst_o,
    output logic [N-1:0] pc_o,
    output logic [N-1:0] pcPlus8_o,
    output logic         instValid_o
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD, S_DROP} state_e;

    localparam logic [N-1:0] FOUR       = N'(4);
    localparam logic [N-1:0] EIGHT      = N'(8);
    localparam logic [N-1:0] ALIGN_MASK = ~N'(3);

    state_e       state_q, state_d;
    logic [N-1:0] pcF_q, pcF_d;
    logic [N-1:0] reqAddr_q, reqAddr_d;
    logic [N-1:0] skidInst_q, skidInst_d;
    logic [N-1:0] skidPc_q, skidPc_d;
    logic [N-1:0] inst_q, inst_d;
    logic [N-1:0] pc_q, pc_d;
    logic [N-1:0] pcPlus8_q, pcPlus8_d;
    logic         instValid_q, instValid_d;

    logic         out_free;
    logic [N-1:0] target;
    logic [N-1:0] pcF_plus4;

    assign out_free  = !instValid_q || !stallD_i;
    assign target    = branchTarget_i & ALIGN_MASK;
    assign pcF_plus4 = pcF_q + FOUR;

    // State register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: redirect has priority over everything else. A redirect in
    // DROP keeps waiting for the stale response, even if it arrives that cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: state_d = S_WAIT;
            S_WAIT: begin
                if (pcSrc_i) begin
                    state_d = imemValid_i ? S_WAIT : S_DROP;
                end else if (imemValid_i && !out_free) begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (pcSrc_i || !stallD_i) begin
                    state_d = S_WAIT;
                end
            end
            S_DROP: begin
                if (!pcSrc_i && imemValid_i) begin
                    state_d = S_WAIT;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs: the request is held through DROP so the stale access completes.
    always_comb begin
        imemReq_o   = (state_q == S_WAIT) || (state_q == S_DROP);
        imemAddr_o  = reqAddr_q;
        inst_o      = inst_q;
        pc_o        = pc_q;
        pcPlus8_o   = pcPlus8_q;
        instValid_o = instValid_q;
    end

    // Datapath next values: PC, request address, skid buffer and F/D register.
    always_comb begin
        pcF_d       = pcF_q;
        reqAddr_d   = reqAddr_q;
        skidInst_d  = skidInst_q;
        skidPc_d    = skidPc_q;
        inst_d      = inst_q;
        pc_d        = pc_q;
        pcPlus8_d   = pcPlus8_q;
        instValid_d = instValid_q;
        if (pcSrc_i) begin
            instValid_d = 1'b0;
            pcF_d       = target;
            if (state_q == S_IDLE || state_q == S_HOLD ||
                (state_q == S_WAIT && imemValid_i)) begin
                reqAddr_d = target;
            end
        end else begin
            case (state_q)
                S_IDLE: reqAddr_d = pcF_q;
                S_WAIT: begin
                    if (imemValid_i) begin
                        pcF_d = pcF_plus4;
                        if (out_free) begin
                            inst_d      = imemRdata_i;
                            pc_d        = reqAddr_q;
                            pcPlus8_d   = reqAddr_q + EIGHT;
                            instValid_d = 1'b1;
                            reqAddr_d   = pcF_plus4;
                        end else begin
                            skidInst_d = imemRdata_i;
                            skidPc_d   = reqAddr_q;
                        end
                    end else if (!stallD_i) begin
                        instValid_d = 1'b0;
                    end
                end
                S_HOLD: begin
                    if (!stallD_i) begin
                        inst_d      = skidInst_q;
                        pc_d        = skidPc_q;
                        pcPlus8_d   = skidPc_q + EIGHT;
                        instValid_d = 1'b1;
                        reqAddr_d   = pcF_q;
                    end
                end
                S_DROP: begin
                    if (imemValid_i) begin
                        reqAddr_d = pcF_q;
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pcF_q       <= RESET_PC;
            reqAddr_q   <= RESET_PC;
            skidInst_q  <= '0;
            skidPc_q    <= '0;
            inst_q      <= '0;
            pc_q        <= '0;
            pcPlus8_q   <= EIGHT;
            instValid_q <= 1'b0;
        end else begin
            pcF_q       <= pcF_d;
            reqAddr_q   <= reqAddr_d;
            skidInst_q  <= skidInst_d;
            skidPc_q    <= skidPc_d;
            inst_q      <= inst_d;
            pc_q        <= pc_d;
            pcPlus8_q   <= pcPlus8_d;
            instValid_q <= instValid_d;
        end
    end

endmodule
